// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY     = 2'd1,
        SIGN_FIX = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Quotient pattern reported for a zero divisor; sliced to the quotient width.
    localparam logic [63:0] ZERO_DIV_Q = '1;

    // Width of the iteration counter that counts down from iters-1.
    function automatic int unsigned cnt_width(input int unsigned iters);
        return (iters <= 1) ? 1 : $clog2(iters);
    endfunction

endpackage

// File: rtl/div_step_unit.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module div_step_unit #(
    parameter int unsigned M = 4
) (
    input  logic [M-1:0] rem_in,
    input  logic         bit_in,
    input  logic [M-1:0] divisor,
    output logic [M-1:0] rem_out,
    output logic         q_bit
);

    logic [M:0] trial;

    // rem_in < divisor, so a successful subtraction always fits back in M bits.
    always_comb begin
        trial   = {rem_in, bit_in};
        q_bit   = (trial >= {1'b0, divisor});
        rem_out = q_bit ? M'(trial - {1'b0, divisor}) : trial[M-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider retiring R quotient bits per cycle.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (adds a SIGN_FIX cycle).
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned M = 4,
    parameter int unsigned R = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [M-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned ITERS = N / R;
    localparam int unsigned CW    = cnt_width(ITERS);

    if ((N % R != 0) || (N < M) || (M < 2)) begin : g_param_check
        $error("seq_divider: R must divide N, N >= M and M >= 2");
    end

    state_t         state_q, state_nxt;
    logic [CW-1:0]  cnt_q, cnt_nxt;
    logic [M-1:0]   rem_q, rem_nxt;
    logic [M-1:0]   dsr_q, dsr_nxt;
    logic [N-1:0]   shreg_q, shreg_nxt;
    logic [N-1:0]   quotient_nxt;
    logic [M-1:0]   remainder_nxt;
    logic           dbz_nxt, in_ready_nxt, out_valid_nxt;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic           q_neg_q, q_neg_nxt, r_neg_q, r_neg_nxt;
`endif

    // shreg holds the unconsumed dividend bits on top and the quotient bits below.
    logic [M-1:0]   chain_rem [R+1];
    logic [R-1:0]   q_bits;
    logic [N-1:0]   shreg_step;

    assign chain_rem[0] = rem_q;

    for (genvar k = 0; k < R; k++) begin : g_step
        div_step_unit #(.M(M)) u_step (
            .rem_in  (chain_rem[k]),
            .bit_in  (shreg_q[N-1-k]),
            .divisor (dsr_q),
            .rem_out (chain_rem[k+1]),
            .q_bit   (q_bits[R-1-k])
        );
    end

    assign shreg_step = (shreg_q << R) | N'(q_bits);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dsr_q       <= '0;
            shreg_q     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            rem_q       <= rem_nxt;
            dsr_q       <= dsr_nxt;
            shreg_q     <= shreg_nxt;
            quotient    <= quotient_nxt;
            remainder   <= remainder_nxt;
            div_by_zero <= dbz_nxt;
            in_ready    <= in_ready_nxt;
            out_valid   <= out_valid_nxt;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg_q     <= q_neg_nxt;
            r_neg_q     <= r_neg_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state_q;
        cnt_nxt       = cnt_q;
        rem_nxt       = rem_q;
        dsr_nxt       = dsr_q;
        shreg_nxt     = shreg_q;
        quotient_nxt  = quotient;
        remainder_nxt = remainder;
        dbz_nxt       = div_by_zero;
`ifdef SEQ_DIVIDER_SIGNED_EN
        q_neg_nxt     = q_neg_q;
        r_neg_nxt     = r_neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cnt_nxt = CW'(ITERS - 1);
                    rem_nxt = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                    shreg_nxt = dividend[N-1] ? (~dividend + N'(1)) : dividend;
                    dsr_nxt   = divisor[M-1] ? (~divisor + M'(1)) : divisor;
                    q_neg_nxt = dividend[N-1] ^ divisor[M-1];
                    r_neg_nxt = dividend[N-1];
`else
                    shreg_nxt = dividend;
                    dsr_nxt   = divisor;
`endif
                    if (divisor == '0) begin
                        state_nxt     = DONE;
                        quotient_nxt  = ZERO_DIV_Q[N-1:0];
                        remainder_nxt = dividend[M-1:0];
                        dbz_nxt       = 1'b1;
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                rem_nxt   = chain_rem[R];
                shreg_nxt = shreg_step;
                cnt_nxt   = cnt_q - CW'(1);
                if (cnt_q == '0) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    state_nxt = SIGN_FIX;
`else
                    state_nxt     = DONE;
                    quotient_nxt  = shreg_step;
                    remainder_nxt = chain_rem[R];
                    dbz_nxt       = 1'b0;
`endif
                end
            end
            SIGN_FIX: begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                // MIN/-1 negates the magnitude MIN back to MIN, which is the wanted result.
                state_nxt     = DONE;
                quotient_nxt  = q_neg_q ? (~shreg_q + N'(1)) : shreg_q;
                remainder_nxt = r_neg_q ? (~rem_q + M'(1)) : rem_q;
                dbz_nxt       = 1'b0;
`else
                state_nxt = IDLE;
`endif
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        in_ready_nxt  = (state_nxt == IDLE);
        out_valid_nxt = (state_nxt == DONE);
    end

endmodule
